axil_master_cmd: RTL
====================

Name: axil_master_cmd

Overview:
- AXI4-Lite initiator that turns a simple valid/ready command stream into single AXI4-Lite read or write transactions, then returns the response on a valid/ready response stream.
- Lets fabric logic (sequencers, self-test, boot init) reach the register file over the same AXI4-Lite bus the processor uses, through an interconnect slave port.
- One outstanding transaction at a time.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width of the command and AW/AR channels.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported; wstrb width is C_M_AXI_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only when AXIM_TIMEOUT_EN is defined.

Ports:
- M_AXI_ACLK  in  1  clock; every signal is synchronous to it.
- M_AXI_ARESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY  out/out/out/in  ADDR_W/3/1/1  write address channel.
- M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  write data channel.
- M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY  out/out/out/in  ADDR_W/3/1/1  read address channel.
- M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  read data channel.

Behaviour:
- **Reset values:** while M_AXI_ARESET=1 at a clock edge, the FSM goes to IDLE and these outputs are 0: AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_write, rsp_rdata, rsp_resp. cmd_ready is 0. Address, data and strobe registers are cleared to 0.
- **Reset mid-transaction:** the transaction is abandoned with no response. The whole bus is assumed to be reset together.
- **AWPROT/ARPROT:** constant 3'b000.
- **Command capture:** cmd_ready=1 only in IDLE. On handshake, addr, wdata, wstrb and write are registered. Command inputs are ignored in every other state.
- **FSM states:**
  - IDLE: accept a command. Write goes to WR; read goes to RD.
  - WR: AWVALID and WVALID both assert the cycle after acceptance. Each valid drops independently on its own handshake (AW before W, W before AW, or same cycle are all legal). Once both have completed, go to WR_B with BREADY=1.
  - WR_B: on BVALID, capture BRESP, set rsp_rdata=0, drop BREADY, go to RSP.
  - RD: ARVALID=1 until ARREADY, then go to RD_R with RREADY=1.
  - RD_R: on RVALID, capture RDATA and RRESP, drop RREADY, go to RSP.
  - RSP: rsp_valid=1, held stable until rsp_ready. Go to IDLE on the cycle after the handshake.
- **Valid stability:** no valid drops without its handshake, and no AXI output changes while its valid is high and ready is low.
- **Minimum latency** with all readies tied high:
  - cmd accept at cycle 0.
  - AW/W or AR valid at cycle 1.
  - B or R accepted at cycle 2.
  - rsp_valid at cycle 3.
  - Next cmd_ready at cycle 4, if rsp_ready was high at cycle 3.
- **Response codes:** rsp_resp passes through unchanged, including SLVERR and DECERR. No retry.

Optional Feature:
- Macro: AXIM_TIMEOUT_EN.
- **Defined:**
  - A counter clears on every command acceptance and increments in WR, WR_B, RD and RD_R.
  - When it reaches TIMEOUT_CYCLES, sticky output timeout_err (out, 1) sets to 1. It is cleared only by reset.
  - The transaction still waits for its completion, so AXI protocol is never violated.
  - The counter saturates and does not wrap.
- **Not defined:** the timeout_err port and the counter do not exist.

Test Plan:
- **Write then read back:** write cmd addr 0x08, wdata 0x0000000A, wstrb 0xF into the regfile → rsp_resp=0, rsp_write=1, led=4'hA. Then read 0x08 → rsp_rdata=0x0000000A.
- **Read-only registers:** read 0x00 → 0x07010100, resp 0. Read 0x04 → 0xDEADBEEF.
- **Skewed readies:** slave BFM gives WREADY 3 cycles before AWREADY, then AWREADY 3 cycles before WREADY → exactly one AW and one W handshake each, with AWADDR/WDATA held stable throughout.
- **Back-pressure and ignored commands:** hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_rdata stay stable, and cmd_valid pulses during this time are not accepted.
- **Error passthrough:** BFM returns BRESP=2'b10 → rsp_resp=2'b10. Mid-transaction reset while AWVALID=1 → all valids 0 and FSM in IDLE the next cycle.
- **Timeout (AXIM_TIMEOUT_EN, TIMEOUT_CYCLES=16):** BFM withholds ARREADY for 20 cycles → timeout_err=1 after 16 cycles. The read still completes with correct data, and timeout_err stays 1 afterwards.

Source files
------------

// File: rtl/axil_master_cmd.sv
// AXI4-Lite initiator: one cmd -> one AR or AW+W transaction -> one rsp; 3 cycles accept-to-rsp_valid at minimum.
// Single outstanding; rsp held until rsp_ready, cmd_ready only in IDLE. AXIM_TIMEOUT_EN adds a sticky watchdog flag.
module axil_master_cmd #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
`ifdef AXIM_TIMEOUT_EN
    output logic                              timeout_err,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_width
        $error("axil_master_cmd supports only a 32-bit data path");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD,
        S_RD_R,
        S_RSP
    } state_t;

    state_t                              r_state;
    logic                                r_cmd_ready;
    logic                                r_awvalid;
    logic                                r_wvalid;
    logic                                r_bready;
    logic                                r_arvalid;
    logic                                r_rready;
    logic                                r_rsp_valid;
    logic                                r_rsp_write;
    logic [1:0]                          r_rsp_resp;
    logic [C_M_AXI_DATA_WIDTH-1:0]       r_rsp_rdata;
    logic [C_M_AXI_ADDR_WIDTH-1:0]       r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]       r_wdata;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]     r_wstrb;
    logic                                w_aw_done;
    logic                                w_w_done;
    logic                                w_accept;

    // A channel counts as done if it already handshook or is handshaking now.
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid  || M_AXI_WREADY;
    assign w_accept  = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_resp  <= 2'b00;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= '0;
                        r_rsp_write <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RD: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_write <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AXIM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_to_cnt;
    logic          r_timeout_err;
    logic          w_busy;

    assign w_busy = (r_state == S_WR) || (r_state == S_WR_B) ||
                    (r_state == S_RD) || (r_state == S_RD_R);

    // Flag only; the transaction keeps waiting so the bus protocol stays intact.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept)
                r_to_cnt <= '0;
            else if (w_busy && (r_to_cnt != CW'(TIMEOUT_CYCLES)))
                r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == CW'(TIMEOUT_CYCLES))
                r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`endif

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
